// File: rtl/t_scan_mux_if.sv
// Channel bus between the data sources / display driver and the scanning multiplexer.
// The master side owns the channel data and controls; the slave side returns the selection.
interface t_scan_mux_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 13,
  parameter int SELW  = 4
);
  logic [CH*WIDTH-1:0] x;
  logic [CH-1:0]       en_mask;
  logic                mode;
  logic [SELW-1:0]     man_sel;
  logic [WIDTH-1:0]    y;
  logic [SELW-1:0]     sel;
  logic                step;
  logic                all_off;

  modport master (
    output x, en_mask, mode, man_sel,
    input  y, sel, step, all_off
  );

  modport slave (
    input  x, en_mask, mode, man_sel,
    output y, sel, step, all_off
  );
endinterface

// File: rtl/t_scan_mux.sv
// Registered time-division scanning multiplexer: steps through enabled channels at a
// programmable dwell rate, or follows a manual select, and presents data plus index.
module t_scan_mux #(
  parameter int WIDTH = 8,
  parameter int CH    = 13,
  parameter int SELW  = 4,
  parameter int DIV   = 100000
) (
  input logic          clk,
  input logic          reset,
  t_scan_mux_if.slave  scan
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0]    cnt_p0;
  logic [SELW-1:0]  sel_p0;
  logic [WIDTH-1:0] y_p0;
  logic             step_p0;
  logic             all_off_p0;

  logic             tick;
  logic [SELW-1:0]  sel_nx;
  logic             blank;
  logic [WIDTH-1:0] y_nx;

  // First enabled channel after cur, wrapping; a full lap with nothing else enabled
  // lands back on cur (or never matches for an empty mask), so sel holds.
  function automatic logic [SELW-1:0] scan_next(input logic [SELW-1:0] cur,
                                                input logic [CH-1:0]   mask);
    logic [SELW-1:0] res;
    logic            found;
    int              idx;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= CH; k++) begin
      idx = (int'(cur) + k) % CH;
      if (!found && mask[idx]) begin
        res   = SELW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic mask_bit(input logic [CH-1:0]   mask,
                                    input logic [SELW-1:0] s);
    logic b;
    b = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (SELW'(i) == s) b = mask[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] pick_chan(input logic [CH*WIDTH-1:0] d,
                                                 input logic [SELW-1:0]     s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      if (SELW'(i) == s) r = d[i*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic [SELW-1:0] manual_sel(input logic [SELW-1:0] s);
    return (int'(s) >= CH) ? '0 : s;
  endfunction

  // Stage 0 input side: next selection and its (possibly blanked) data
  always_comb begin
    tick   = (cnt_p0 == CNT_MAX);
    sel_nx = sel_p0;
    if (scan.mode) begin
      sel_nx = manual_sel(scan.man_sel);
    end else if (tick) begin
      sel_nx = scan_next(sel_p0, scan.en_mask);
    end
    blank = (scan.en_mask == '0) || !mask_bit(scan.en_mask, sel_nx);
    y_nx  = blank ? '0 : pick_chan(scan.x, sel_nx);
  end

  // Stage 0 registers: prescaler runs freely in both modes, only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_p0     <= '0;
      sel_p0     <= '0;
      y_p0       <= '0;
      step_p0    <= 1'b0;
      all_off_p0 <= 1'b0;
    end else begin
      cnt_p0     <= tick ? '0 : cnt_p0 + 1'b1;
      sel_p0     <= sel_nx;
      y_p0       <= y_nx;
      step_p0    <= (sel_nx != sel_p0);
      all_off_p0 <= (scan.en_mask == '0);
    end
  end

  assign scan.y       = y_p0;
  assign scan.sel     = sel_p0;
  assign scan.step    = step_p0;
  assign scan.all_off = all_off_p0;

endmodule

// File: tb/tb_t_scan_mux.sv
// Directed bench for t_scan_mux with CH=13, WIDTH=8, DIV=4 and channel i carrying 8'h10+i.
module tb_t_scan_mux;

  localparam int WIDTH = 8;
  localparam int CH    = 13;
  localparam int SELW  = 4;
  localparam int DIV   = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  t_scan_mux_if #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) bus ();

  t_scan_mux #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .scan  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input int s, input int yv, input int st);
    check({tag, ".sel"},  32'(bus.sel),  32'(s));
    check({tag, ".y"},    32'(bus.y),    32'(yv));
    check({tag, ".step"}, 32'(bus.step), 32'(st));
  endtask

  initial begin
    n_checks    = 0;
    n_err       = 0;
    reset       = 1'b1;
    bus.mode    = 1'b0;
    bus.man_sel = '0;
    bus.en_mask = 13'h1FFF;
    for (int i = 0; i < CH; i++) bus.x[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
    cyc(2);
    check_out("rst", 0, 0, 0);
    check("rst.all_off", 32'(bus.all_off), 0);

    // Full scan: edges are counted from reset release
    reset = 1'b0;
    cyc(1);
    check_out("scan.e1", 0, 'h10, 0);
    check("scan.e1.all_off", 32'(bus.all_off), 0);
    cyc(2);
    check_out("scan.e3", 0, 'h10, 0);
    cyc(1);
    check_out("scan.e4", 1, 'h11, 1);
    cyc(1);
    check_out("scan.e5", 1, 'h11, 0);
    cyc(3);
    for (int c = 2; c < CH; c++) begin
      check_out($sformatf("scan.ch%0d", c), c, 'h10 + c, 1);
      cyc(4);
    end
    check_out("scan.wrap", 0, 'h10, 1);

    // Skip: channels 0, 2, 5 (edge 52 just passed, ticks at multiples of 4)
    bus.en_mask = 13'b0_0000_0010_0101;
    cyc(4);
    check_out("skip.2", 2, 'h12, 1);
    cyc(1);
    check_out("skip.2hold", 2, 'h12, 0);
    cyc(3);
    check_out("skip.5", 5, 'h15, 1);
    cyc(3);
    check_out("skip.5dwell", 5, 'h15, 0);
    cyc(1);
    check_out("skip.0", 0, 'h10, 1);

    // Single channel 3, then empty mask
    bus.en_mask = 13'h0008;
    cyc(4);
    check_out("single.3", 3, 'h13, 1);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      check($sformatf("single.hold%0d.step", k), 32'(bus.step), 0);
    end
    check("single.sel", 32'(bus.sel), 3);
    bus.en_mask = '0;
    cyc(1);
    check_out("empty", 3, 0, 0);
    check("empty.all_off", 32'(bus.all_off), 1);
    cyc(4);
    check_out("empty.tick", 3, 0, 0);

    // Manual select
    bus.en_mask = 13'h1FFF;
    bus.mode    = 1'b1;
    bus.man_sel = 4'd7;
    cyc(1);
    check_out("man.7", 7, 'h17, 1);
    check("man.all_off", 32'(bus.all_off), 0);
    cyc(1);
    check_out("man.7hold", 7, 'h17, 0);
    bus.man_sel = 4'd14;
    cyc(1);
    check_out("man.14", 0, 'h10, 1);
    bus.mode = 1'b0;
    cyc(3);
    check_out("resume.wait", 0, 'h10, 0);
    cyc(1);
    check_out("resume.1", 1, 'h11, 1);

    // Live data and blanking on channel 4
    cyc(12);
    check_out("live.4", 4, 'h14, 1);
    bus.x[4*WIDTH +: WIDTH] = 8'hAA;
    cyc(1);
    check_out("live.aa", 4, 'hAA, 0);
    bus.en_mask = 13'h1FEF;
    cyc(1);
    check_out("blank.4", 4, 0, 0);
    cyc(1);
    check_out("blank.4b", 4, 0, 0);
    cyc(1);
    check_out("blank.tick", 5, 'h15, 1);
    bus.x[4*WIDTH +: WIDTH] = 8'h14;
    bus.en_mask = 13'h1FFF;

    // Reset mid-scan at sel=9, cnt=2
    cyc(18);
    check_out("mid.9", 9, 'h19, 0);
    #2 reset = 1'b1;
    #1;
    check_out("async.rst", 0, 0, 0);
    check("async.all_off", 32'(bus.all_off), 0);
    cyc(2);
    reset = 1'b0;
    cyc(3);
    check_out("rerun.e3", 0, 'h10, 0);
    cyc(1);
    check_out("rerun.e4", 1, 'h11, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/t_scan_mux.md
# t_scan_mux

Parametrised, registered, time-division scanning multiplexer. It is the successor to the fixed 13-way 8-bit display selector. It steps through CH input channels of WIDTH bits at a programmable dwell rate and skips channels that are masked off. It also supports a manual select mode. It sits between the per-digit/per-field data sources and the display driver, and supplies both the selected data and the active channel index.

## Interface
- WIDTH, 8, bit width of each channel
- CH, 13, number of channels (2..16)
- SELW, 4, select width; must satisfy 2^SELW >= CH
- DIV, 100000, clock cycles per scan step (dwell); DIV >= 2

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- x  in  CH*WIDTH  packed channel data; channel i at x[i*WIDTH +: WIDTH]
- en_mask  in  CH  per-channel enable; bit i = 1 includes channel i in the scan
- mode  in  1  0 = auto scan, 1 = manual select
- man_sel  in  SELW  channel index used in manual mode
- y  out  WIDTH  registered selected data
- sel  out  SELW  registered active channel index
- step  out  1  one-cycle pulse on every cycle in which sel changes value
- all_off  out  1  registered; 1 when en_mask == 0

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps to 0. It runs continuously in both modes and is never cleared except by reset. Internal tick = (cnt == DIV-1).
- Auto mode (mode=0): on tick, sel_next = the first index j in sel+1, sel+2, …, wrapping CH-1→0, with en_mask[j]=1. The search covers at most CH positions.
  - If the only enabled channel is the current sel, sel holds and step stays 0.
  - If en_mask == 0, sel holds.
  - Between ticks, sel holds.
- Manual mode (mode=1): sel_next = man_sel every cycle, with no tick dependency. If man_sel >= CH, sel_next = 0. The mask does not affect selection in manual mode.
- Data path, every cycle: y <= (en_mask == 0 || en_mask[sel_next] == 0) ? 0 : x[sel_next]. y is always aligned with sel, and a disabled or blank channel shows all-zero data.
- step <= (sel_next != sel).
- all_off <= (en_mask == 0).
- Mode change manual→auto: scanning resumes from the current sel at the next tick, and the prescaler phase is kept. Mode change auto→manual: takes effect on the next edge.
- A mask change while dwelling on a channel that becomes disabled: y goes to 0 on the next edge. sel moves at the next tick only (auto mode).

## Timing
- Reset (asynchronous assert, synchronous release): cnt=0, sel=0, y=0, step=0, all_off=0.
- On the first edge after release, y, step and all_off take their computed values. Example: mask bit 0 = 1 gives y = x[0].
- Auto mode: the first sel change happens on the DIV-th rising edge after reset release. After that, sel changes every DIV cycles.
- Latency from x to y is 1 cycle. Latency from man_sel to sel and y is 1 cycle. Latency from en_mask to y and all_off is 1 cycle.
- step is asserted in the same cycle the new sel is visible. It is never asserted for two consecutive cycles in auto mode.
- Simultaneous tick and mode=1: manual wins. Simultaneous tick and mask change: the search uses the current-cycle en_mask.
- Purely synchronous, single clock domain. No combinational path from inputs to outputs.

## Test plan
Bench configuration: CH=13, WIDTH=8, DIV=4, x[i]=8'h10+i.

- Full scan: mask=13'h1FFF, mode=0, reset released. Required: sel=0 and y=8'h10 for edges 1–3, then sel=1 and y=8'h11 at edge 4. sel reaches 12 and y=8'h1C, then wraps to sel=0 with step=1 on each change.
- Skip: mask=13'b0_0000_0010_0101 (ch 0, 2, 5). Required: sel sequence 0→2→5→0, step=1 at each change, dwell of 4 cycles each.
- Single and empty mask: mask with only bit 3 set. Required: sel settles at 3 and holds, step stays 0 afterwards. Then mask=0. Required: y=8'h00 and all_off=1 one cycle later, sel unchanged.
- Manual: mode=1, man_sel=7 → sel=7, y=8'h17 after 1 cycle, step=1 for one cycle. Then man_sel=14 → sel=0, y=8'h10. Then mode=0 → scan resumes 0→1 at the next tick.
- Live data and blanking: while sel=4, change x[4] to 8'hAA → y=8'hAA one cycle later. Clear mask bit 4 → y=8'h00 next cycle, sel still 4 until the tick.
- Reset mid-scan: assert reset while sel=9 and cnt=2. Required: all outputs 0 immediately (asynchronous). After release, the first advance occurs exactly 4 edges later.
